// File: rtl/qu_instr_queue.sv
// qu_instr_queue: in-order decode-to-dispatch FIFO with flush, NOP dropping and first-word fall-through
module qu_instr_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic                     in_nop,
  input  logic                     in_invalid,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic                     out_invalid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = INSTR_WIDTH + PC_WIDTH + 1;
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0] rptr, wptr;
  logic empty, full, push, pop;
  assign empty = rptr == wptr;
  assign full = (rptr[AW-1:0] == wptr[AW-1:0]) && (rptr[AW] != wptr[AW]);
  // reset forces the handshake low exactly like a flush
  assign in_ready = ~full & ~flush & ~rst;
  assign out_valid = ~empty & ~flush & ~rst;
  assign push = in_valid & in_ready & ~in_nop;
  assign pop = out_valid & out_ready;
  assign {out_instr, out_pc, out_invalid} = mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr + (AW+1)'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= {in_instr, in_pc, in_invalid};
endmodule

// File: tb/tb_qu_instr_queue.sv
// tb_qu_instr_queue: table-driven checks of fill, drain, streaming wrap, flush, NOP and invalid handling
module tb_qu_instr_queue;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_nop = 0, in_invalid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid, out_invalid;
  logic [31:0] out_instr, out_pc;
  logic [3:0] count;
  int checks = 0, errors = 0;

  qu_instr_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_nop(in_nop), .in_invalid(in_invalid), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_invalid(out_invalid), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl, iv, nop, inv, ordy;
    logic [31:0] pc;
    logic e_ir, e_ov, e_inv;
    logic [31:0] e_pc;
    logic [3:0] e_cnt;
  } vec_t;
  vec_t v[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h13 + (pc >> 2);
  endfunction

  task automatic add(input logic fl, iv, nop, inv, ordy, input logic [31:0] pc,
                     input logic e_ir, e_ov, e_inv, input logic [31:0] e_pc, input logic [3:0] e_cnt);
    vec_t r;
    r.fl = fl; r.iv = iv; r.nop = nop; r.inv = inv; r.ordy = ordy; r.pc = pc;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_inv = e_inv; r.e_pc = e_pc; r.e_cnt = e_cnt;
    v.push_back(r);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // fill 8 with the consumer stalled; head stays at PC 0
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, 4*i, 1, i > 0, 0, 0, 4'(i));
    add(0, 1, 0, 0, 0, 32'h20, 0, 1, 0, 0, 8);
    // drain in order
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 1, 0, i > 0, 1, 0, 4*i, 4'(8 - i));
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // refill, then push+pop while full: only the pop completes
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, 32'h40 + 4*i, 1, i > 0, 0, 32'h40, 4'(i));
    add(0, 1, 0, 0, 1, 32'h60, 0, 1, 0, 32'h40, 8);
    add(0, 1, 0, 0, 0, 32'h60, 1, 1, 0, 32'h44, 7);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h44, 8);
    // drain 3 to leave 5, then flush with valid traffic on both sides
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, i > 0, 1, 0, 32'h44 + 4*i, 4'(8 - i));
    add(1, 1, 0, 0, 1, 32'h99, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 0, 32'h4, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h4, 1);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h4, 1);
    // held flush stays empty and stalled
    add(1, 1, 0, 0, 1, 32'h8, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 32'h8, 0, 0, 0, 0, 0);
    // NOP dropped, invalid queued in order
    add(0, 1, 1, 0, 0, 32'h10, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 32'h14, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h18, 1, 1, 1, 32'h14, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h14, 2);
    add(0, 0, 0, 0, 1, 0, 1, 1, 1, 32'h14, 2);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h18, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // streaming with wrap: each entry visible one cycle after its push
    for (int i = 0; i < 20; i++) add(0, 1, 0, 0, 1, 32'h100 + 4*i, 1, i > 0, 0, 32'h100 + 4*(i-1), 4'(i > 0));
    add(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h100 + 4*19, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    @(posedge clk); #1;
    check("rst_in_ready", -1, 32'(in_ready), 0);
    check("rst_out_valid", -1, 32'(out_valid), 0);
    @(posedge clk); #1;
    rst = 0; #1;
    check("post_rst_in_ready", -1, 32'(in_ready), 1);
    check("post_rst_out_valid", -1, 32'(out_valid), 0);
    check("post_rst_count", -1, 32'(count), 0);

    foreach (v[i]) begin
      flush = v[i].fl; in_valid = v[i].iv; in_nop = v[i].nop; in_invalid = v[i].inv;
      out_ready = v[i].ordy; in_pc = v[i].pc; in_instr = instr_of(v[i].pc);
      #1;
      check("in_ready", i, 32'(in_ready), 32'(v[i].e_ir));
      check("out_valid", i, 32'(out_valid), 32'(v[i].e_ov));
      check("count", i, 32'(count), 32'(v[i].e_cnt));
      if (v[i].e_ov) begin
        check("out_pc", i, out_pc, v[i].e_pc);
        check("out_instr", i, out_instr, instr_of(v[i].e_pc));
        check("out_invalid", i, 32'(out_invalid), 32'(v[i].e_inv));
      end
      @(posedge clk); #1;
    end

    // reset mid-content empties the queue and wins over flush-free traffic
    in_valid = 1; in_nop = 0; in_invalid = 0; flush = 0; out_ready = 0; in_pc = 32'h200; in_instr = instr_of(32'h200);
    @(posedge clk); #1;
    in_valid = 0; rst = 1; #1;
    check("rst_force_in_ready", -2, 32'(in_ready), 0);
    check("rst_force_out_valid", -2, 32'(out_valid), 0);
    @(posedge clk); #1;
    rst = 0; #1;
    check("rst2_count", -2, 32'(count), 0);
    check("rst2_out_valid", -2, 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qu_instr_queue.md
Name: qu_instr_queue

Overview:
Decoupling FIFO between the Qu decode stage and the rename/dispatch stage. It captures decoded instruction words with their PC and status flags. It presents them in program order to the downstream consumer over a valid/ready handshake. It drives backpressure to decode (the core's id_stall is derived from ~in_ready) and empties on any redirect (branch, jump or exception).

Parameters:
INSTR_WIDTH, 32 (QU_INSTR_WIDTH), width of the instruction word
PC_WIDTH, 32 (QU_PC_WIDTH), width of the PC carried with each entry
DEPTH, 8, number of entries; must be a power of two and >= 2

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  redirect (branch | jump | exception); empties the queue
in_valid  in  1  decode presents an instruction this cycle
in_instr  in  INSTR_WIDTH  decoded instruction word
in_pc  in  PC_WIDTH  PC of in_instr
in_nop  in  1  slot is a bubble; consumed but not stored
in_invalid  in  1  decode flagged the instruction as illegal
in_ready  out  1  queue can accept an entry this cycle
out_valid  out  1  head entry is available
out_instr  out  INSTR_WIDTH  head instruction word
out_pc  out  PC_WIDTH  head PC
out_invalid  out  1  head illegal-instruction flag
out_ready  in  1  consumer takes the head this cycle
count  out  $clog2(DEPTH)+1  current number of stored entries

Behaviour:
- Storage: DEPTH entries of {instr, pc, invalid}. Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty. Pointers wrap modulo DEPTH.
- Storage contents are not reset. Only the pointers and count are reset.
- empty = (rptr == wptr). full = index bits equal and MSBs differ.
- Handshake flags:
  - in_ready = ~full & ~flush.
  - out_valid = ~empty & ~flush.
- Push: occurs when in_valid & in_ready & ~in_nop. The entry is written at wptr and wptr increments.
- NOP slot: in_valid & in_ready & in_nop is accepted (the handshake completes) but nothing is written.
- Pop: occurs when out_valid & out_ready; rptr increments.
- Head data: out_* are driven combinationally from the entry at rptr (first-word fall-through). When out_valid = 0, out_* values are don't-care.
- Latency: no bypass. An entry pushed at edge N is visible on out_* with out_valid = 1 from edge N until it is popped, so enqueue-to-dequeue takes a minimum of 1 cycle.
- Simultaneous push and pop:
  - Not full: both happen and count is unchanged.
  - Full: in_ready = 0, so only the pop happens. No same-cycle refill of a full queue.
  - Empty: only the push happens, because out_valid = 0 that cycle.
- count tracks wptr - rptr. It is registered and reflects the state after the previous edge.
- Flush: while flush = 1, in_ready and out_valid are forced to 0, so no transfer completes in that cycle. At the edge, rptr = wptr = 0 and count = 0. Flush held for several cycles keeps the queue empty and stalled.
- Reset: while rst = 1, the same forcing applies as for flush. At the edge, rptr = wptr = 0 and count = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, count = 0.
  - out_instr, out_pc and out_invalid are undefined after reset.
- Priority: rst > flush > push/pop.
- Invalid entries are queued in order with out_invalid = 1 so the exception is raised at the correct program position. The queue does not act on them.
- Entries are never reordered, duplicated or dropped, except NOP slots and entries discarded by flush or rst.

Test Plan:
- Reset then fill: pulse rst for 2 cycles, hold out_ready = 0, push 8 instrs 0x00000013+i with PC 0x0+4i → count steps 1..8; in_ready falls to 0 after the 8th push; the 9th in_valid is held, not lost; out_pc = 0x0 throughout.
- Drain in order: from full, set out_ready = 1 for 8 cycles → out_pc sequence 0x00, 0x04, …, 0x1C; out_valid drops after the 8th pop; count = 0; in_ready = 1.
- Streaming and wrap: out_ready = 1, push 20 consecutive instrs (PC 0x100+4i) → each appears one cycle after its push; count stays at 1; pointers wrap twice with no loss or reorder.
- Flush mid-stream: queue holds 5 entries; assert flush for 1 cycle together with in_valid and out_ready → no pop or push that cycle; count = 0 next cycle; the next push (PC 0x4) appears as the head.
- NOP and invalid handling: push PC 0x10 with nop = 1, then PC 0x14 with invalid = 1, then PC 0x18 → queue holds only 0x14 (out_invalid = 1) and 0x18 (out_invalid = 0); count = 2.
- Full with simultaneous pop: queue full, in_valid = 1, out_ready = 1 → the pop completes, no push that cycle, count = 7; the next cycle the push completes and count = 8.
